// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_sequencer
// Brief    : Operand FIFO and issue sequencer for a banked signed MAC array.
//            Captures each vector's dot product onto a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module mac_dot_sequencer #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int LANES  = 2,
    parameter int ID_W   = 2,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_last,
    input  logic [ID_W-1:0]   cfg_lane,
    output logic [ID_W-1:0]   mac_id,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [LEN_W-1:0]  res_len,
    output logic              res_err
);

    localparam int                c_addr_w  = $clog2(DEPTH);
    localparam int                c_entry_w = 2 * DATA_W + 1;
    localparam logic [ID_W:0]     c_lanes   = (ID_W + 1)'(LANES);
    localparam logic [LEN_W-1:0]  c_len_max = '1;

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Operand FIFO: {a, b, last}; pointers carry one extra wrap bit
    // ------------------------------------------------------------------
    logic [c_entry_w-1:0] fifo_mem_q [DEPTH];
    logic [c_entry_w-1:0] fifo_mem_d [DEPTH];
    logic [c_addr_w:0]    wr_ptr_q, wr_ptr_d;
    logic [c_addr_w:0]    rd_ptr_q, rd_ptr_d;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 do_push;
    logic                 do_pop;
    logic [c_entry_w-1:0] head;
    logic [DATA_W-1:0]    head_a;
    logic [DATA_W-1:0]    head_b;
    logic                 head_last;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      mac_id_q, mac_id_d;
    logic [DATA_W-1:0]    mac_a_q, mac_a_d;
    logic [DATA_W-1:0]    mac_b_q, mac_b_d;
    logic                 mac_clr_q, mac_clr_d;
    logic                 res_valid_q, res_valid_d;
    logic [ACC_W-1:0]     res_data_q, res_data_d;
    logic [LEN_W-1:0]     res_len_q, res_len_d;
    logic                 res_err_q, res_err_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 err_q, err_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[c_addr_w] != rd_ptr_q[c_addr_w]) &&
                        (wr_ptr_q[c_addr_w-1:0] == rd_ptr_q[c_addr_w-1:0]);

    // Ready tracks occupancy only, so a full FIFO never accepts a pair even
    // when the head is being popped in the same cycle.
    assign s_ready = !fifo_full && !reset;
    assign do_push = s_valid && s_ready;
    assign do_pop  = (state_q == ST_ISSUE) && !fifo_empty;

    assign head      = fifo_mem_q[rd_ptr_q[c_addr_w-1:0]];
    assign head_a    = head[c_entry_w-1 -: DATA_W];
    assign head_b    = head[DATA_W:1];
    assign head_last = head[0];

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (do_push) begin
            fifo_mem_d[wr_ptr_q[c_addr_w-1:0]] = {s_a, s_b, s_last};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock0) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // ------------------------------------------------------------------
    // Issue / capture sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mac_id_d    = mac_id_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_clr_d   = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_len_d   = res_len_q;
        res_err_d   = res_err_q;
        len_d       = len_q;
        err_d       = err_q;

        case (state_q)
            ST_ISSUE: begin
                if (do_pop) begin
                    mac_a_d = head_a;
                    mac_b_d = head_b;
                    // len never wraps back to zero, so zero marks a first pop
                    if (len_q == '0) begin
                        if ({1'b0, cfg_lane} >= c_lanes) begin
                            mac_id_d = '0;
                            err_d    = 1'b1;
                        end else begin
                            mac_id_d = cfg_lane;
                        end
                    end
                    if (len_q != c_len_max) begin
                        len_d = len_q + 1'b1;
                    end
                    if (head_last) begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    mac_a_d = '0;
                    mac_b_d = '0;
                end
            end

            ST_WAIT: begin
                mac_a_d = '0;
                mac_b_d = '0;
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                mac_a_d     = '0;
                mac_b_d     = '0;
                res_data_d  = mac_out;
                res_len_d   = len_q;
                res_err_d   = err_q;
                res_valid_d = 1'b1;
                mac_clr_d   = 1'b1;
                len_d       = '0;
                err_d       = 1'b0;
                state_d     = ST_RESULT;
            end

            ST_RESULT: begin
                mac_a_d = '0;
                mac_b_d = '0;
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            state_q     <= ST_ISSUE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mac_id_q    <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_clr_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
            len_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mac_id_q    <= mac_id_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_clr_q   <= mac_clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_len_q   <= res_len_d;
            res_err_q   <= res_err_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end

    assign mac_id    = mac_id_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_clr   = mac_clr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_dot_sequencer
// Brief    : Scoreboard bench for mac_dot_sequencer with a behavioural MAC bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_dot_sequencer;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int LANES  = 2;
    localparam int ID_W   = 2;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = 8;

    logic              clock0 = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              s_last;
    logic [ID_W-1:0]   cfg_lane;
    logic [ID_W-1:0]   mac_id;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_clr;
    logic [ACC_W-1:0]  mac_out;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [LEN_W-1:0]  res_len;
    logic              res_err;

    always #5 clock0 = ~clock0;

    mac_dot_sequencer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES),
        .ID_W(ID_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clock0   (clock0),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a      (s_a),
        .s_b      (s_b),
        .s_last   (s_last),
        .cfg_lane (cfg_lane),
        .mac_id   (mac_id),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_clr  (mac_clr),
        .mac_out  (mac_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_len  (res_len),
        .res_err  (res_err)
    );

    // Behavioural MAC bank; clear is ORed with reset as in the system
    logic [ACC_W-1:0]        acc [4];
    logic signed [ACC_W-1:0] ext_a, ext_b;
    assign ext_a   = {{(ACC_W-DATA_W){mac_a[DATA_W-1]}}, mac_a};
    assign ext_b   = {{(ACC_W-DATA_W){mac_b[DATA_W-1]}}, mac_b};
    assign mac_out = acc[mac_id];

    always @(posedge clock0) begin
        if (reset || mac_clr) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            acc[mac_id] <= acc[mac_id] + ext_a * ext_b;
        end
    end

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [LEN_W-1:0] len;
        logic             err;
        logic [ID_W-1:0]  id;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

    exp_t  sb_q[$];
    pair_t pair_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic signed [ACC_W-1:0] cur_sum;
    logic [LEN_W-1:0]        cur_len;
    logic [ID_W-1:0]         vec_lane;

    task automatic push_pair(input logic signed [DATA_W-1:0] a,
                             input logic signed [DATA_W-1:0] b,
                             input logic last);
        int    n;
        exp_t  e;
        logic signed [ACC_W-1:0] pa, pb;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        s_valid = 1'b1;
        n = 0;
        @(negedge clock0);
        while (!s_ready && n < 200) begin
            @(negedge clock0);
            n++;
        end
        if (!s_ready) chk("push_timeout", 32'd0, 32'd1);
        @(posedge clock0);
        #1;
        s_valid = 1'b0;
        pair_q.push_back('{a, b});
        pa = ACC_W'(a);
        pb = ACC_W'(b);
        cur_sum = cur_sum + pa * pb;
        if (cur_len != '1) cur_len = cur_len + 1'b1;
        if (last) begin
            e.data = cur_sum;
            e.len  = cur_len;
            e.err  = (32'(vec_lane) >= LANES);
            e.id   = e.err ? '0 : vec_lane;
            sb_q.push_back(e);
            cur_sum = '0;
            cur_len = '0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clock0);
            #1;
            n++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic start_vec(input logic [ID_W-1:0] lane);
        vec_lane = lane;
        cfg_lane = lane;
    endtask

    // Output monitor: operand stream, clear pulse, result hold and scoreboard
    logic             prev_valid = 1'b0;
    logic             prev_hs    = 1'b0;
    logic             prev_reset = 1'b1;
    logic [ACC_W-1:0] prev_data  = '0;

    always @(negedge clock0) begin
        pair_t p;
        exp_t  e;
        if (reset) begin
            prev_reset = 1'b1;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            chk("mac_clr", 32'(mac_clr), 32'(prev_reset || (res_valid && !prev_valid)));
            if (prev_valid && !prev_hs) begin
                chk("res_hold_valid", 32'(res_valid), 32'd1);
                chk("res_hold_data", res_data, prev_data);
            end
            if (res_valid) begin
                chk("no_pop_a", 32'(mac_a), 32'd0);
                chk("no_pop_b", 32'(mac_b), 32'd0);
            end
            if (mac_a != '0 || mac_b != '0) begin
                if (pair_q.size() == 0) begin
                    chk("extra_issue", 32'd1, 32'd0);
                end else begin
                    p = pair_q.pop_front();
                    chk("issue_a", 32'(mac_a), 32'(p.a));
                    chk("issue_b", 32'(mac_b), 32'(p.b));
                    if (sb_q.size() != 0) chk("issue_id", 32'(mac_id), 32'(sb_q[0].id));
                end
            end
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    chk("extra_result", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_len", 32'(res_len), 32'(e.len));
                    chk("res_err", 32'(res_err), 32'(e.err));
                    chk("res_id", 32'(mac_id), 32'(e.id));
                end
            end
            prev_reset = 1'b0;
            prev_valid = res_valid;
            prev_hs    = res_valid && res_ready;
            prev_data  = res_data;
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_a       = '0;
        s_b       = '0;
        s_last    = 1'b0;
        cfg_lane  = '0;
        res_ready = 1'b1;
        cur_sum   = '0;
        cur_len   = '0;
        vec_lane  = '0;

        repeat (3) @(posedge clock0);
        @(negedge clock0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd1);
        chk("rst_mac_a", 32'(mac_a), 32'd0);
        chk("rst_mac_b", 32'(mac_b), 32'd0);
        chk("rst_mac_id", 32'(mac_id), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_len", 32'(res_len), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        @(posedge clock0);
        #1;
        reset = 1'b0;

        // Basic vector on lane 1: 12 - 10 - 7 = -5
        start_vec(2'd1);
        push_pair(16'sd3, 16'sd4, 1'b0);
        push_pair(-16'sd2, 16'sd5, 1'b0);
        push_pair(16'sd7, -16'sd1, 1'b1);
        wait_done();

        // Result backpressure with a second vector filling the FIFO
        res_ready = 1'b0;
        start_vec(2'd1);
        push_pair(16'sd10, 16'sd10, 1'b0);
        push_pair(-16'sd1, 16'sd3, 1'b1);
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clock0);
            #1;
            n++;
        end
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        push_pair(16'sd1, 16'sd2, 1'b0);
        push_pair(16'sd3, 16'sd4, 1'b0);
        push_pair(16'sd5, 16'sd6, 1'b0);
        push_pair(16'sd7, 16'sd8, 1'b0);
        @(negedge clock0);
        chk("bp_full", 32'(s_ready), 32'd0);
        repeat (10) @(negedge clock0);
        chk("bp_still_full", 32'(s_ready), 32'd0);
        chk("bp_still_valid", 32'(res_valid), 32'd1);
        @(posedge clock0);
        #1;
        res_ready = 1'b1;
        push_pair(16'sd9, 16'sd10, 1'b1);
        wait_done();

        // Four (-32768)^2 products sum to 2^32, which wraps to zero
        start_vec(2'd0);
        for (int i = 0; i < 4; i++) push_pair(-16'sd32768, -16'sd32768, i == 3);
        wait_done();

        // Single-pair vector on an out-of-range lane
        start_vec(2'd3);
        push_pair(16'sd100, -16'sd3, 1'b1);
        wait_done();

        // Bubbles between pairs
        start_vec(2'd1);
        for (int i = 0; i < 5; i++) begin
            push_pair(16'sd1, 16'sd1, i == 4);
            if (i < 4) begin
                @(posedge clock0);
                #1;
            end
        end
        wait_done();

        // Reset in the middle of a vector
        start_vec(2'd1);
        push_pair(16'sd5, 16'sd5, 1'b0);
        push_pair(16'sd6, 16'sd6, 1'b0);
        @(posedge clock0);
        #1;
        reset = 1'b1;
        pair_q.delete();
        cur_sum = '0;
        cur_len = '0;
        repeat (3) @(posedge clock0);
        @(negedge clock0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        @(posedge clock0);
        #1;
        reset = 1'b0;
        @(negedge clock0);
        chk("post_rst_clr", 32'(mac_clr), 32'd1);
        @(posedge clock0);
        #1;
        start_vec(2'd0);
        push_pair(16'sd2, 16'sd2, 1'b1);
        wait_done();

        repeat (3) @(posedge clock0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
